// File: rtl/msk_and_dom_pipe.sv
// msk_and_dom_pipe: DOM-masked W-lane AND over D shares, with an optional registered compression stage
module msk_and_dom_pipe #(
  parameter int D = 2,
  parameter int W = 8,
  parameter int PIPE = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [D*W-1:0]               ina,
  input  logic [D*W-1:0]               inb,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [W*(D*(D-1)/2)-1:0]     rnd,
  input  logic                         rnd_valid,
  output logic                         rnd_ack,
  output logic [D*W-1:0]               out,
  output logic                         out_valid,
  input  logic                         out_ready
);
  localparam int R = D*(D-1)/2;
  logic [D*D*W-1:0] p, p_next;
  logic [D*W-1:0]   comp;
  logic             s1_valid, accept, adv;
  assign accept   = in_valid & rnd_valid & in_ready & rst_n;
  assign rnd_ack  = accept;
  assign in_ready = !s1_valid | adv;
  genvar i, j, k;
  for (i = 0; i < D; i++) begin : g_row
    for (j = 0; j < D; j++) begin : g_col
      for (k = 0; k < W; k++) begin : g_lane
        if (i == j) begin : g_diag
          assign p_next[(i*D+j)*W+k] = ina[i*W+k] & inb[j*W+k];
        end else begin : g_cross
          localparam int lo = (i < j) ? i : j;
          localparam int hi = (i < j) ? j : i;
          assign p_next[(i*D+j)*W+k] = (ina[i*W+k] & inb[j*W+k]) ^ rnd[k*R + lo*D - lo*(lo+1)/2 + hi-1-lo];
        end
      end
    end
  end
  // share i = XOR over j of the registered cross products
  always_comb begin
    comp = '0;
    for (int s = 0; s < D; s++)
      for (int t = 0; t < D; t++)
        comp[s*W +: W] = comp[s*W +: W] ^ p[(s*D+t)*W +: W];
  end
  // cross-product register: loads only with fresh randomness
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) p <= '0;
    else if (accept) p <= p_next;
  // stage-1 occupancy
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) s1_valid <= 1'b0;
    else if (accept | adv) s1_valid <= accept;
  if (PIPE != 0) begin : g_pipe
    logic [D*W-1:0] s2;
    logic           s2_valid;
    assign adv       = s1_valid & (!s2_valid | out_ready);
    assign out       = s2;
    assign out_valid = s2_valid;
    // stage-2 holds the compressed shares until the consumer takes them
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        s2       <= '0;
        s2_valid <= 1'b0;
      end else begin
        if (adv) s2 <= comp;
        if (adv | out_ready) s2_valid <= adv;
      end
  end else begin : g_flat
    assign adv       = s1_valid & out_ready;
    assign out       = comp;
    assign out_valid = s1_valid;
  end
endmodule
